// File: rtl/router_pkt_fifo.sv
// Packet-aware synchronous FIFO for one router output port.
// Stores each byte with its header tag and tracks complete packets on both sides.
module router_pkt_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 2,
    parameter int DEPTH       = 16,
    parameter int AFULL_LEVEL = 14
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     soft_reset,
    input  logic                     write_en,
    input  logic                     lfd_state,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic                     read_en,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     data_valid,
    output logic                     pkt_done,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   pkt_count,
    output logic                     hdr_err
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int LEN_W  = DATA_WIDTH - ADDR_WIDTH;
    localparam int PLEN_W = LEN_W + 1;
    localparam logic [CNT_W-1:0] PKT_MAX = '1;

    // Bit DATA_WIDTH of each entry is the header tag.
    logic [DATA_WIDTH:0] mem [DEPTH];

    logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]      occ_reg, occ_next;
    logic [PLEN_W-1:0]     wr_cnt_reg, wr_cnt_next;
    logic [PLEN_W-1:0]     rd_cnt_reg, rd_cnt_next;
    logic [CNT_W-1:0]      pkt_count_reg, pkt_count_next;
    logic [DATA_WIDTH-1:0] data_out_reg, data_out_next;
    logic                  data_valid_reg, data_valid_next;
    logic                  pkt_done_reg, pkt_done_next;
    logic                  hdr_err_reg, hdr_err_next;

    logic                  wr_acc, rd_acc, mem_we;
    logic                  pkt_inc, pkt_dec;
    logic [DATA_WIDTH:0]   rd_word;
    logic                  rd_lfd;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [PLEN_W-1:0]     wr_hdr_len, rd_hdr_len;

    assign full        = (occ_reg == CNT_W'(DEPTH));
    assign empty       = (occ_reg == '0);
    assign almost_full = (occ_reg >= CNT_W'(AFULL_LEVEL));

    assign wr_acc = write_en && !full;
    assign rd_acc = read_en && !empty;
    assign mem_we = wr_acc && !soft_reset;

    assign rd_word = mem[rd_ptr_reg];
    assign rd_lfd  = rd_word[DATA_WIDTH];
    assign rd_data = rd_word[DATA_WIDTH-1:0];

    // A header announces payload_len payload bytes plus one parity byte.
    assign wr_hdr_len = {1'b0, data_in[DATA_WIDTH-1:ADDR_WIDTH]} + PLEN_W'(1);
    assign rd_hdr_len = {1'b0, rd_data[DATA_WIDTH-1:ADDR_WIDTH]} + PLEN_W'(1);

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[wr_ptr_reg] <= {lfd_state, data_in};
        end
    end

    always_comb begin
        wr_ptr_next     = wr_ptr_reg;
        rd_ptr_next     = rd_ptr_reg;
        occ_next        = occ_reg;
        wr_cnt_next     = wr_cnt_reg;
        rd_cnt_next     = rd_cnt_reg;
        pkt_count_next  = pkt_count_reg;
        data_out_next   = data_out_reg;
        data_valid_next = rd_acc;
        pkt_done_next   = 1'b0;
        hdr_err_next    = 1'b0;
        pkt_inc         = 1'b0;
        pkt_dec         = 1'b0;

        if (wr_acc) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            if (lfd_state) begin
                hdr_err_next = (wr_cnt_reg != '0);
                wr_cnt_next  = wr_hdr_len;
            end else if (wr_cnt_reg != '0) begin
                wr_cnt_next = wr_cnt_reg - PLEN_W'(1);
                pkt_inc     = (wr_cnt_reg == PLEN_W'(1));
            end
        end

        if (rd_acc) begin
            rd_ptr_next   = rd_ptr_reg + PTR_W'(1);
            data_out_next = rd_data;
            if (rd_lfd) begin
                rd_cnt_next = rd_hdr_len;
            end else if (rd_cnt_reg != '0) begin
                rd_cnt_next   = rd_cnt_reg - PLEN_W'(1);
                pkt_dec       = (rd_cnt_reg == PLEN_W'(1));
                pkt_done_next = pkt_dec;
            end
        end

        case ({wr_acc, rd_acc})
            2'b10:   occ_next = occ_reg + CNT_W'(1);
            2'b01:   occ_next = occ_reg - CNT_W'(1);
            default: occ_next = occ_reg;
        endcase

        // Saturate rather than wrap if orphaned bytes unbalance the two sides.
        if (pkt_inc && !pkt_dec && (pkt_count_reg != PKT_MAX)) begin
            pkt_count_next = pkt_count_reg + CNT_W'(1);
        end else if (!pkt_inc && pkt_dec && (pkt_count_reg != '0)) begin
            pkt_count_next = pkt_count_reg - CNT_W'(1);
        end

        if (soft_reset) begin
            wr_ptr_next     = '0;
            rd_ptr_next     = '0;
            occ_next        = '0;
            wr_cnt_next     = '0;
            rd_cnt_next     = '0;
            pkt_count_next  = '0;
            data_out_next   = '0;
            data_valid_next = 1'b0;
            pkt_done_next   = 1'b0;
            hdr_err_next    = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            occ_reg        <= '0;
            wr_cnt_reg     <= '0;
            rd_cnt_reg     <= '0;
            pkt_count_reg  <= '0;
            data_out_reg   <= '0;
            data_valid_reg <= 1'b0;
            pkt_done_reg   <= 1'b0;
            hdr_err_reg    <= 1'b0;
        end else begin
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            occ_reg        <= occ_next;
            wr_cnt_reg     <= wr_cnt_next;
            rd_cnt_reg     <= rd_cnt_next;
            pkt_count_reg  <= pkt_count_next;
            data_out_reg   <= data_out_next;
            data_valid_reg <= data_valid_next;
            pkt_done_reg   <= pkt_done_next;
            hdr_err_reg    <= hdr_err_next;
        end
    end

    assign data_out   = data_out_reg;
    assign data_valid = data_valid_reg;
    assign pkt_done   = pkt_done_reg;
    assign hdr_err    = hdr_err_reg;
    assign pkt_count  = pkt_count_reg;

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Randomised and directed bench for router_pkt_fifo, checked every cycle
// against a queue-based reference model.
module tb_router_pkt_fifo;

    localparam int DEPTH = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       soft_reset = 1'b0;
    logic       write_en = 1'b0;
    logic       lfd_state = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       read_en = 1'b0;
    logic [7:0] data_out;
    logic       data_valid, pkt_done, full, empty, almost_full, hdr_err;
    logic [4:0] pkt_count;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    router_pkt_fifo #(
        .DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(DEPTH), .AFULL_LEVEL(14)
    ) dut (
        .clock(clock), .reset(reset), .soft_reset(soft_reset),
        .write_en(write_en), .lfd_state(lfd_state), .data_in(data_in),
        .read_en(read_en), .data_out(data_out), .data_valid(data_valid),
        .pkt_done(pkt_done), .full(full), .empty(empty),
        .almost_full(almost_full), .pkt_count(pkt_count), .hdr_err(hdr_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {header tag, byte} plus per-side packet byte budgets.
    logic [8:0] mq[$];
    int         m_wr = 0, m_rd = 0, m_pkt = 0;
    logic [7:0] m_dout = 8'h00;
    bit         m_dv = 0, m_done = 0, m_herr = 0;

    always @(posedge clock or posedge reset) begin
        logic [8:0] e;
        bit wa, ra;
        int inc, dec;
        if (reset || soft_reset) begin
            mq.delete();
            m_wr = 0; m_rd = 0; m_pkt = 0;
            m_dout = 8'h00; m_dv = 0; m_done = 0; m_herr = 0;
        end else begin
            wa = write_en && (mq.size() < DEPTH);
            ra = read_en && (mq.size() > 0);
            inc = 0; dec = 0;
            m_dv = ra; m_done = 0; m_herr = 0;
            if (ra) begin
                e = mq.pop_front();
                m_dout = e[7:0];
                if (e[8]) m_rd = int'(e[7:2]) + 1;
                else if (m_rd != 0) begin
                    m_rd--;
                    if (m_rd == 0) begin m_done = 1; dec = 1; end
                end
            end
            if (wa) begin
                mq.push_back({lfd_state, data_in});
                if (lfd_state) begin
                    if (m_wr != 0) m_herr = 1;
                    m_wr = int'(data_in[7:2]) + 1;
                end else if (m_wr != 0) begin
                    m_wr--;
                    if (m_wr == 0) inc = 1;
                end
            end
            m_pkt = m_pkt + inc - dec;
            if (m_pkt < 0) m_pkt = 0;
            if (m_pkt > 31) m_pkt = 31;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("data_out",    data_out,    m_dout);
            chk("data_valid",  data_valid,  m_dv);
            chk("pkt_done",    pkt_done,    m_done);
            chk("hdr_err",     hdr_err,     m_herr);
            chk("full",        full,        mq.size() == DEPTH);
            chk("empty",       empty,       mq.size() == 0);
            chk("almost_full", almost_full, mq.size() >= 14);
            chk("pkt_count",   pkt_count,   m_pkt);
        end
    end

    task automatic step(input bit we, input bit lfd, input logic [7:0] din,
                        input bit re, input bit sr = 1'b0);
        @(negedge clock);
        write_en = we; lfd_state = lfd; data_in = din; read_en = re; soft_reset = sr;
        @(posedge clock);
        #1;
    endtask

    logic [7:0] pay[16];
    logic [8:0] pend[$];

    task automatic write_3a_packet();
        pay[0] = 8'h3A;
        for (int i = 1; i < 15; i++) pay[i] = 8'($urandom);
        pay[15] = 8'h5C;
        for (int i = 0; i < 16; i++) step(1'b1, i == 0, pay[i], 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk_en = 1'b1;

        // Reset sanity: asynchronous reset between clock edges.
        step(1, 1, 8'h01, 0);
        step(1, 0, 8'hA5, 0);
        step(0, 0, 8'h00, 1);
        chk("pre_reset_valid", data_valid, 1);
        chk("pre_reset_dout", data_out, 8'h01);
        #1 reset = 1'b1;
        #1;
        chk("rst_dout", data_out, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_pkt_count", pkt_count, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // One 16-byte packet fills the FIFO; a 17th write is dropped.
        write_3a_packet();
        chk("pkt1_count", pkt_count, 1);
        chk("pkt1_model_count", m_pkt, 1);
        chk("pkt1_full", full, 1);
        chk("pkt1_afull", almost_full, 1);
        step(1, 0, 8'hEE, 0);
        chk("pkt1_extra_full", full, 1);
        chk("pkt1_extra_count", pkt_count, 1);
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 8'h00, 1);
            chk("pkt1_seq", data_out, pay[i]);
            chk("pkt1_done", pkt_done, i == 15);
        end
        chk("pkt1_drain_count", pkt_count, 0);
        chk("pkt1_drain_empty", empty, 1);

        // Concurrent read+write while full: only the read is accepted.
        write_3a_packet();
        step(1, 0, 8'hEE, 1);
        chk("full_rw_dout", data_out, 8'h3A);
        chk("full_rw_full", full, 0);
        for (int i = 0; i < 15; i++) step(0, 0, 8'h00, 1);
        chk("full_rw_drain_empty", empty, 1);
        chk("full_rw_drain_count", pkt_count, 0);

        // Concurrent read+write at occupancy 5 across pointer wrap.
        for (int i = 0; i < 5; i++) step(1, 0, 8'h10 + 8'(i), 0);
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 8'h20 + 8'(i), 1);
            chk("occ5_order", data_out, (i < 5) ? (8'h10 + 8'(i)) : (8'h20 + 8'(i - 5)));
        end
        chk("occ5_nonempty", empty, 0);
        chk("occ5_model_size", mq.size(), 5);
        for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 1);

        // Two minimum-length packets back to back.
        step(1, 1, 8'h01, 0);
        step(1, 0, 8'h77, 0);
        chk("bb_count1", pkt_count, 1);
        step(1, 1, 8'h02, 0);
        step(1, 0, 8'h88, 0);
        chk("bb_count2", pkt_count, 2);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 8'h00, 1);
            chk("bb_valid", data_valid, 1);
            chk("bb_done", pkt_done, (i == 1) || (i == 3));
        end
        chk("bb_count0", pkt_count, 0);

        // Header arriving while a len-3 packet is still open.
        step(1, 1, 8'h0C, 0);
        step(1, 0, 8'h41, 0);
        step(1, 1, 8'h0C, 0);
        chk("herr_pulse", hdr_err, 1);
        chk("herr_count", pkt_count, 0);
        step(0, 0, 8'h00, 0);
        chk("herr_clear", hdr_err, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 8'h50 + 8'(i), 0);
        chk("herr_new_pkt", pkt_count, 1);
        for (int i = 0; i < 7; i++) begin
            step(0, 0, 8'h00, 1);
            chk("herr_rd_done", pkt_done, i == 6);
        end
        chk("herr_final_count", pkt_count, 0);

        // Soft reset overrides a simultaneous read and write.
        for (int i = 0; i < 9; i++) step(1, 0, 8'h60 + 8'(i), 0);
        step(1, 1, 8'h3A, 1, 1);
        chk("srst_empty", empty, 1);
        chk("srst_count", pkt_count, 0);
        chk("srst_valid", data_valid, 0);
        chk("srst_dout", data_out, 0);
        step(0, 0, 8'h00, 0);
        chk("srst_no_write", empty, 1);

        // Randomised packet traffic with occasional truncation, strays and flushes.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit we, re, sr, lfd;
            logic [7:0] d;
            if (pend.size() == 0) begin
                int r;
                r = int'($urandom % 30);
                if (r == 0) pend.push_back({1'b0, 8'($urandom)});
                else begin
                    logic [5:0] len;
                    int n;
                    len = 6'($urandom % 6);
                    pend.push_back({1'b1, len, 2'($urandom % 4)});
                    n = int'(len) + 1;
                    if (r == 1) n = int'($urandom % n);
                    for (int k = 0; k < n; k++) pend.push_back({1'b0, 8'($urandom)});
                end
            end
            we = ($urandom % 4) != 0;
            re = ($urandom % 100) < ((cyc < 1500) ? 40 : 75);
            sr = ($urandom % 300) == 0;
            lfd = pend[0][8];
            d = pend[0][7:0];
            if (we && !sr && (mq.size() < DEPTH)) void'(pend.pop_front());
            step(we, lfd, d, re, sr);
        end
        step(0, 0, 8'h00, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/router_pkt_fifo.md
Name: router_pkt_fifo

Overview:
- Parametrised, packet-aware synchronous FIFO for the router output channels. Next generation of the per-port router FIFO.
- Stores each byte with its header (lfd) tag and tracks packet boundaries on both the write and read sides.
- Reports the number of complete packets buffered, an almost-full level, per-packet read completion and header protocol errors.
- Sits between the router register/FSM stage (write side) and one destination port (read side).

Parameters:
DATA_WIDTH, 8, byte width; header = {payload_len[DATA_WIDTH-1:ADDR_WIDTH], addr[ADDR_WIDTH-1:0]}
ADDR_WIDTH, 2, destination-address field width inside the header
DEPTH, 16, entries; power of two, >= 4
AFULL_LEVEL, 14, occupancy at or above which almost_full asserts (1..DEPTH)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous active-high reset
soft_reset  in  1  synchronous flush (time-out from the router FSM)
write_en  in  1  write request
lfd_state  in  1  qualifies data_in as a header byte
data_in  in  DATA_WIDTH  write data
read_en  in  1  read request
data_out  out  DATA_WIDTH  registered read data
data_valid  out  1  data_out updated this cycle
pkt_done  out  1  pulse: last (parity) byte of a packet is on data_out
full  out  1  occupancy == DEPTH
empty  out  1  occupancy == 0
almost_full  out  1  occupancy >= AFULL_LEVEL
pkt_count  out  $clog2(DEPTH)+1  complete packets resident
hdr_err  out  1  pulse: header written while a packet is still open

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Ports are named clock and reset.
- Storage: DEPTH x (DATA_WIDTH+1); bit DATA_WIDTH holds lfd_state. Pointers have $clog2(DEPTH) bits and wrap modulo DEPTH. occupancy has $clog2(DEPTH)+1 bits.
- reset (async) or soft_reset (sync, overrides everything that cycle):
  - pointers, occupancy, wr_cnt, rd_cnt and pkt_count go to 0.
  - data_out = 0; data_valid, pkt_done and hdr_err go to 0.
  - Resulting state: empty = 1, full = 0, almost_full = 0. Memory contents are don't-care.
- Write accepted iff write_en && !full. Read accepted iff read_en && !empty. Flags are the registered values of the current cycle.
- Read and write in the same cycle are both accepted if flags permit, and occupancy is unchanged:
  - when full, only the read is accepted;
  - when empty, only the write is accepted.
- Write-side tracking:
  - Accepted write with lfd=1: wr_cnt <= payload_len + 1 (payload + parity). If wr_cnt != 0 at that point, hdr_err pulses for 1 cycle; the orphaned partial packet stays in memory and is not counted.
  - Accepted write with lfd=0 and wr_cnt != 0: wr_cnt decrements. On the transition 1 -> 0, the packet is complete and pkt_count increments.
  - Accepted write with lfd=0 and wr_cnt == 0 (stray byte): the byte is stored, nothing else changes.
- Read-side tracking:
  - Latency is 1 cycle: an accepted read in cycle N gives data_out/data_valid in N+1. data_out holds its value when no read is accepted; data_valid is 0 then.
  - Popped header entry: rd_cnt <= payload_len + 1.
  - Popped non-header entry with rd_cnt != 0: rd_cnt decrements. On the transition 1 -> 0, pkt_done pulses together with data_valid, and pkt_count decrements.
- If a pkt_count increment and decrement happen in the same cycle, pkt_count is unchanged. pkt_count never wraps.
- payload_len = 0 is legal: the packet is 2 bytes (header + parity).

Test Plan:
- Reset sanity: assert reset mid-clock with no clock edge -> outputs immediately 0; empty = 1, pkt_count = 0.
- One packet, header 8'h3A (len 14, addr 2'b10): 14 random payload bytes, parity 8'h5C. After the parity write, pkt_count = 1 and occupancy = 16 -> full = 1, almost_full = 1. A 17th write is ignored. Hold read_en for 16 cycles -> data_out sequence matches, pkt_done high only on 8'h5C, then pkt_count = 0 and empty = 1.
- Concurrent read+write at occupancy 16 (DEPTH 16) -> only the read is accepted. At occupancy 5 -> occupancy stays 5 and both data streams stay in order across the pointer wrap.
- Two back-to-back 2-byte packets (headers 8'h01 and 8'h02, len 0) -> pkt_count steps 1 then 2. Reading them out gives pkt_done on the 2nd and 4th data_valid.
- Header 8'h0C written after only 1 payload byte of an open len-3 packet -> hdr_err pulses 1 cycle, pkt_count unchanged, new packet tracked correctly.
- soft_reset with 9 bytes stored while read_en and write_en are also high -> next cycle empty = 1, pkt_count = 0, data_valid = 0, no write stored.
